// File: rtl/peak_dpu_pkg.sv
// Shared DPU constants: instruction-length encoding and aligner queue geometry.
package peak_dpu_pkg;

    localparam logic [1:0] C_OP_LEN32        = 2'b11;
    localparam int         C_IALIGN_HW_DEPTH = 4;
    localparam int         C_HW_W            = 16;

endpackage

// File: rtl/peak_dpu_ialign.sv
// Instruction aligner: queues halfwords from word-aligned fetches and presents one
// RV32C/RV32I instruction per cycle to instr1 decode, with halfword-granular redirect.
module peak_dpu_ialign
    import peak_dpu_pkg::*;
#(
    parameter logic [31:0] RST_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_vld,
    input  logic [31:0] fetch_addr,
    input  logic [31:0] fetch_data,
    output logic        fetch_rdy,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        instr1_vld,
    output logic [31:0] instr1_op,
    output logic        instr1_is_compressed,
    output logic [31:0] instr1_pc,
    input  logic        instr1_rdy
);

    logic [C_HW_W-1:0] hw_q [C_IALIGN_HW_DEPTH];
    logic [C_HW_W-1:0] hw_d [C_IALIGN_HW_DEPTH];
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       head_pc_q, head_pc_d;
    logic              skip_lo_q, skip_lo_d;

    logic              is_len32;
    logic              pop;
    logic              push;
    logic [2:0]        pop_cnt;
    logic [2:0]        push_cnt;
    logic [2:0]        wr_idx;
    logic [C_HW_W-1:0] wr_first;

    // Address ordering is owned by the fetch unit; the address is not consumed here.
    logic unused_fetch_addr;
    assign unused_fetch_addr = ^fetch_addr;

    assign is_len32   = (hw_q[0][1:0] == C_OP_LEN32);
    assign instr1_vld = is_len32 ? (cnt_q >= 3'd2) : (cnt_q >= 3'd1);
    assign instr1_op  = !instr1_vld ? 32'h0 :
                        is_len32    ? {hw_q[1], hw_q[0]} : {16'h0, hw_q[0]};
    assign instr1_is_compressed = instr1_vld & ~is_len32;
    assign instr1_pc  = head_pc_q;
    assign fetch_rdy  = (cnt_q <= 3'd2);

    assign pop      = instr1_vld & instr1_rdy;
    assign push     = fetch_vld & fetch_rdy;
    assign pop_cnt  = !pop  ? 3'd0 : (is_len32  ? 3'd2 : 3'd1);
    assign push_cnt = !push ? 3'd0 : (skip_lo_q ? 3'd1 : 3'd2);
    assign wr_idx   = cnt_q - pop_cnt;
    assign wr_first = skip_lo_q ? fetch_data[31:16] : fetch_data[15:0];

    // Each entry: shift out the popped halfwords, then overlay the pushed ones at wr_idx.
    for (genvar gi = 0; gi < C_IALIGN_HW_DEPTH; gi++) begin : g_entry
        logic [C_HW_W-1:0] hw_shift;

        if (gi + 2 < C_IALIGN_HW_DEPTH) begin : g_sh2
            assign hw_shift = (pop_cnt == 3'd2) ? hw_q[gi+2] :
                              (pop_cnt == 3'd1) ? hw_q[gi+1] : hw_q[gi];
        end else if (gi + 1 < C_IALIGN_HW_DEPTH) begin : g_sh1
            assign hw_shift = (pop_cnt == 3'd2) ? '0 :
                              (pop_cnt == 3'd1) ? hw_q[gi+1] : hw_q[gi];
        end else begin : g_sh0
            assign hw_shift = (pop_cnt == 3'd0) ? hw_q[gi] : '0;
        end

        assign hw_d[gi] = (push && !flush && wr_idx == 3'(gi)) ? wr_first :
                          (push && !flush && !skip_lo_q && (wr_idx + 3'd1) == 3'(gi))
                                                              ? fetch_data[31:16] :
                          hw_shift;
    end

    always_comb begin
        cnt_d     = cnt_q;
        head_pc_d = head_pc_q;
        skip_lo_d = skip_lo_q;
        if (flush) begin
            cnt_d     = 3'd0;
            head_pc_d = flush_pc;
            skip_lo_d = flush_pc[1];
        end else begin
            cnt_d     = cnt_q - pop_cnt + push_cnt;
            head_pc_d = head_pc_q + {28'h0, pop_cnt, 1'b0};
            if (push) begin
                skip_lo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_IALIGN_HW_DEPTH; i++) begin
                hw_q[i] <= '0;
            end
            cnt_q     <= 3'd0;
            head_pc_q <= RST_PC;
            skip_lo_q <= RST_PC[1];
        end else begin
            for (int i = 0; i < C_IALIGN_HW_DEPTH; i++) begin
                hw_q[i] <= hw_d[i];
            end
            cnt_q     <= cnt_d;
            head_pc_q <= head_pc_d;
            skip_lo_q <= skip_lo_d;
        end
    end

endmodule

// File: tb/tb_peak_dpu_ialign.sv
// Bench for peak_dpu_ialign: directed scenarios plus random traffic, all checked
// against a halfword-queue reference model.
module tb_peak_dpu_ialign;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_vld;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_rdy;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr1_vld;
    logic [31:0] instr1_op;
    logic        instr1_is_compressed;
    logic [31:0] instr1_pc;
    logic        instr1_rdy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain halfword queue, PC of head, pending low-half discard.
    logic [15:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_skip;

    peak_dpu_ialign #(.RST_PC(32'h0000_0000)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_vld            (fetch_vld),
        .fetch_addr           (fetch_addr),
        .fetch_data           (fetch_data),
        .fetch_rdy            (fetch_rdy),
        .flush                (flush),
        .flush_pc             (flush_pc),
        .instr1_vld           (instr1_vld),
        .instr1_op            (instr1_op),
        .instr1_is_compressed (instr1_is_compressed),
        .instr1_pc            (instr1_pc),
        .instr1_rdy           (instr1_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic m_len32();
        return (m_q.size() > 0) && (m_q[0][1:0] == 2'b11);
    endfunction

    function automatic logic m_vld();
        if (m_q.size() == 0) return 1'b0;
        return m_len32() ? (m_q.size() >= 2) : 1'b1;
    endfunction

    function automatic logic [31:0] m_op();
        if (!m_vld()) return 32'h0;
        return m_len32() ? {m_q[1], m_q[0]} : {16'h0, m_q[0]};
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_pc   = 32'h0;
        m_skip = 1'b0;
    endtask

    task automatic check_model(input string where);
        check_eq({where, "_vld"},  {31'h0, instr1_vld}, {31'h0, m_vld()});
        check_eq({where, "_op"},   instr1_op, m_op());
        check_eq({where, "_comp"}, {31'h0, instr1_is_compressed}, {31'h0, m_vld() & ~m_len32()});
        check_eq({where, "_pc"},   instr1_pc, m_pc);
        check_eq({where, "_frdy"}, {31'h0, fetch_rdy}, {31'h0, m_q.size() <= 2});
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance both.
    task automatic step(input logic fv, input logic [31:0] fa, input logic [31:0] fd,
                        input logic fl, input logic [31:0] fpc, input logic rdy);
        logic accept;
        logic take;
        int   n;
        fetch_vld  = fv;
        fetch_addr = fa;
        fetch_data = fd;
        flush      = fl;
        flush_pc   = fpc;
        instr1_rdy = rdy;
        check_model("mdl");
        accept = fv && (m_q.size() <= 2);
        take   = m_vld() && rdy;
        n      = m_len32() ? 2 : 1;
        @(posedge clk);
        if (fl) begin
            m_q.delete();
            m_pc   = fpc;
            m_skip = fpc[1];
        end else begin
            if (take) begin
                for (int k = 0; k < n; k++) void'(m_q.pop_front());
                m_pc = m_pc + 32'(2 * n);
            end
            if (accept) begin
                if (!m_skip) m_q.push_back(fd[15:0]);
                m_q.push_back(fd[31:16]);
                m_skip = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    task automatic push(input logic [31:0] fa, input logic [31:0] fd, input logic rdy);
        step(1'b1, fa, fd, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        rst = 1'b1;
        fetch_vld = 1'b0; fetch_addr = '0; fetch_data = '0;
        flush = 1'b0; flush_pc = '0; instr1_rdy = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_eq("rst_vld",  {31'h0, instr1_vld}, 32'h0);
        check_eq("rst_op",   instr1_op, 32'h0);
        check_eq("rst_pc",   instr1_pc, 32'h0);
        check_eq("rst_frdy", {31'h0, fetch_rdy}, 32'h1);

        // 32-bit instruction
        push(32'h0, 32'h00A00513, 1'b0);
        check_eq("i32_op",   instr1_op, 32'h00A00513);
        check_eq("i32_comp", {31'h0, instr1_is_compressed}, 32'h0);
        check_eq("i32_pc",   instr1_pc, 32'h0);
        idle(1'b1);
        check_eq("i32_done", {31'h0, instr1_vld}, 32'h0);

        // Two compressed instructions from one word
        step(1'b1, 32'h0, 32'h45814501, 1'b1, 32'h0, 1'b1);
        push(32'h0, 32'h45814501, 1'b1);
        check_eq("c2_op0", instr1_op, 32'h00004501);
        check_eq("c2_pc0", instr1_pc, 32'h0);
        idle(1'b1);
        check_eq("c2_op1", instr1_op, 32'h00004581);
        check_eq("c2_pc1", instr1_pc, 32'h2);
        idle(1'b1);
        check_eq("c2_end", {31'h0, instr1_vld}, 32'h0);

        // Straddling 32-bit instruction
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);
        push(32'h0, 32'h05134501, 1'b0);
        check_eq("st_op0", instr1_op, 32'h00004501);
        idle(1'b1);
        check_eq("st_hold", {31'h0, instr1_vld}, 32'h0);
        push(32'h4, 32'h458100A0, 1'b0);
        check_eq("st_op1", instr1_op, 32'h00A00513);
        check_eq("st_pc1", instr1_pc, 32'h2);
        idle(1'b1);
        check_eq("st_op2", instr1_op, 32'h00004581);
        check_eq("st_pc2", instr1_pc, 32'h6);
        idle(1'b1);

        // Flush with cnt=3 and a colliding fetch
        push(32'h8, 32'h45014501, 1'b0);
        push(32'hC, 32'h45014501, 1'b1);
        step(1'b1, 32'h10, 32'h12345678, 1'b1, 32'h102, 1'b1);
        check_eq("fl_vld",  {31'h0, instr1_vld}, 32'h0);
        check_eq("fl_frdy", {31'h0, fetch_rdy}, 32'h1);
        push(32'h100, 32'h4501ABCD, 1'b0);
        check_eq("fl_op", instr1_op, 32'h00004501);
        check_eq("fl_pc", instr1_pc, 32'h102);
        idle(1'b1);

        // Backpressure: stall decode while streaming
        for (int i = 0; i < 4; i++) push(32'h104 + 32'(4 * i), 32'h45814501 + 32'(i << 1), 1'b0);
        check_eq("bp_frdy", {31'h0, fetch_rdy}, 32'h0);
        check_eq("bp_op",   instr1_op, 32'h00004501);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check_eq("bp_drain", {31'h0, instr1_vld}, 32'h0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[1:0] = 2'b11;
            step($urandom_range(0, 3) != 0, 32'h0, d,
                 $urandom_range(0, 49) == 0, {$urandom_range(0, 65535), 1'b0} & 32'h0001_FFFE,
                 $urandom_range(0, 2) != 0);
        end

        // Asynchronous reset with a full queue
        step(1'b0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b0);
        push(32'h40, 32'h00A00513, 1'b0);
        push(32'h44, 32'h00B00593, 1'b0);
        check_eq("ar_pre_frdy", {31'h0, fetch_rdy}, 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_vld",  {31'h0, instr1_vld}, 32'h0);
        check_eq("ar_op",   instr1_op, 32'h0);
        check_eq("ar_comp", {31'h0, instr1_is_compressed}, 32'h0);
        check_eq("ar_pc",   instr1_pc, 32'h0);
        check_eq("ar_frdy", {31'h0, fetch_rdy}, 32'h1);
        m_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        push(32'h0, 32'h45814501, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/peak_dpu_ialign.md
# peak_dpu_ialign

Instruction aligner sitting between the fetch buffer and the instr1 decode stage of the DPU. It accepts word-aligned 32-bit fetch words, keeps them in a 4-halfword queue, and extracts one RV32C/RV32I instruction per cycle. Its output is the `instr1_vld` / `instr1_op` / `instr1_is_compressed` triple, plus the instruction PC. It handles 32-bit instructions that straddle a fetch-word boundary, and redirects to halfword-aligned targets.

## Interface
- `RST_PC`, default `32'h0000_0000`: PC of the first instruction after reset. Bit 0 must be 0.
- `clk`  in  1: core clock, rising-edge.
- `rst`  in  1: reset. Asynchronous, active-high.
- `fetch_vld`  in  1: fetch word valid.
- `fetch_addr`  in  32: byte address of the fetch word. Bits [1:0] are 0.
- `fetch_data`  in  32: fetch word. Little-endian: bits [15:0] hold the halfword at `fetch_addr`.
- `fetch_rdy`  out  1: aligner accepts the fetch word this cycle.
- `flush`  in  1: pipeline redirect.
- `flush_pc`  in  32: redirect target. Halfword-aligned.
- `instr1_vld`  out  1: complete instruction at the head of the queue.
- `instr1_op`  out  32: instruction. Compressed instructions are zero-extended, `{16'h0, hw}`.
- `instr1_is_compressed`  out  1: head instruction is 16-bit.
- `instr1_pc`  out  32: PC of the head instruction.
- `instr1_rdy`  in  1: decode consumes the instruction.

## Operation
- **State**
  - `hw[0..3]`: 16-bit halfword queue; `hw[0]` is the head.
  - `cnt`: 3-bit count, 0..4.
  - `head_pc`: 32-bit PC of the head instruction.
  - `skip_lo`: 1-bit flag; when set, the lower halfword of the next accepted fetch word is discarded.
- **Reset values:** `cnt`=0, `head_pc`=`RST_PC`, `skip_lo`=`RST_PC[1]`, `hw`=0. Resulting outputs: `instr1_vld`=0, `instr1_op`=0, `instr1_is_compressed`=0, `instr1_pc`=`RST_PC`, `fetch_rdy`=1.
- **Extraction (combinational from registers):**
  - `hw[0][1:0]!=2'b11` → compressed; valid when `cnt>=1`.
  - `hw[0][1:0]==2'b11` → 32-bit instruction `{hw[1],hw[0]}`; valid when `cnt>=2`.
  - `instr1_op` and `instr1_is_compressed` are forced to 0 when `instr1_vld`=0.
- **Pop:** occurs on `instr1_vld & instr1_rdy`.
  - Removes 1 halfword (compressed) or 2 halfwords (32-bit).
  - `head_pc` advances by 2 or 4, modulo 2^32.
- **Push:** occurs on `fetch_vld & fetch_rdy`.
  - Pushes 2 halfwords, or only `fetch_data[31:16]` if `skip_lo`=1.
  - Clears `skip_lo`.
  - Halfwords are written at index `cnt - pop_count`.
- **`fetch_rdy`** = `cnt<=2`. It depends on registered `cnt` only, not on the same-cycle pop. Overflow is therefore impossible.
- **Simultaneous push and pop:** both take effect. `cnt_next = cnt - pop_count + push_count`.
- **Flush** has priority over everything:
  - Sets `cnt`=0, `head_pc`=`flush_pc`, `skip_lo`=`flush_pc[1]`.
  - Same-cycle push and pop are discarded, and `fetch_rdy` is still driven as `cnt<=2`.
  - The fetch unit restarts at `{flush_pc[31:2],2'b00}`.
- **Partial 32-bit instruction:** with `cnt`=1 and `hw[0][1:0]==2'b11`, the aligner holds `instr1_vld`=0 until the upper halfword arrives.
- `fetch_addr` is not checked against `head_pc`. Address ordering is the fetch unit's responsibility.

## Timing
- One-cycle latency: a word accepted at edge N is visible on the `instr1_*` outputs after edge N.
- There is no fetch-to-decode combinational bypass. The only input-to-output path is none: `fetch_rdy` and all `instr1_*` outputs come from registers.
- Throughput: one instruction per cycle when the fetch stream is sustained and decode is not stalling.
- While `instr1_vld`=1 and `instr1_rdy`=0, the outputs are held stable.
- Reset assertion mid-operation clears state immediately, independent of `clk`.

## Structure
- **Shared package `peak_dpu_pkg`:**
  - `C_OP_LEN32 = 2'b11`
  - `C_IALIGN_HW_DEPTH = 4`
  - `C_HW_W = 16`
- **No sub-module.** The queue is a 4-entry shift register inside `peak_dpu_ialign`, with a write-index mux.

## Test plan
- **32-bit instruction.** After reset, push `0x00A00513` at addr 0 → next cycle `instr1_vld`=1, `op`=`0x00A00513`, `is_compressed`=0, `pc`=0.
- **Two compressed instructions.** Push `0x45814501` at addr 0, `instr1_rdy`=1 → `op`=`0x00004501` (`pc` 0), then `op`=`0x00004581` (`pc` 2), then `vld`=0.
- **Straddling instruction.** Push `0x05134501`, then `0x458100A0` → outputs in order:
  - `0x4501` at `pc` 0.
  - `0x00A00513` at `pc` 2. This must stay `vld`=0 until the second word is in.
  - `0x4581` at `pc` 6.
- **Flush.** With `cnt`=3, assert `flush` with `flush_pc`=`0x102` and `fetch_vld`=1 in the same cycle → next cycle `vld`=0, `cnt`=0. Then push `0x4501ABCD` at `0x100` → `op`=`0x00004501`, `pc`=`0x102`.
- **Backpressure.** Hold `instr1_rdy`=0 for 4 cycles while streaming words → `fetch_rdy`=0 once `cnt`>2, outputs stable. Release → every instruction appears once, in order.
- **Async reset.** Assert `rst` between clock edges while `cnt`=4 → outputs immediately take their reset values and `fetch_rdy`=1.
